// File: rtl/jk_bank_ctrl_if.sv
// Command handshake and JK bank observation bus for jk_bank_ctrl.
// The host drives the cmd_* fields; the controller returns J/K/Q and status.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNTW-1:0]  cmd_cnt;
  logic [WIDTH-1:0] j_o;
  logic [WIDTH-1:0] k_o;
  logic [WIDTH-1:0] q_o;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt,
    input  cmd_ready, j_o, k_o, q_o, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt,
    output cmd_ready, j_o, k_o, q_o, busy, done, wrap
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of WIDTH JK flip-flops: latches one command,
// drives J/K for the required number of steps, then pulses done.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic          clk,
  input  logic          CLRN,
  jk_bank_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_LOAD   = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_SHIFT  = 3'd7
  } op_t;

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNTW-1:0]  r_steps;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;

  op_t              w_op_in;
  logic [CNTW-1:0]  w_steps_in;
  logic [WIDTH-1:0] w_tup;
  logic [WIDTH-1:0] w_tdn;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap;

  assign w_op_in = op_t'(bus.cmd_op);

  // Multi-step ops take max(cmd_cnt,1) steps; everything else is one step.
  always_comb begin
    w_steps_in = CNTW'(1);
    if ((w_op_in == OP_CNT_UP) || (w_op_in == OP_CNT_DN) || (w_op_in == OP_SHIFT)) begin
      if (bus.cmd_cnt != '0) begin
        w_steps_in = bus.cmd_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      r_state <= S_IDLE;
      r_op    <= OP_HOLD;
      r_data  <= '0;
      r_steps <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.cmd_valid && r_ready) begin
            r_op    <= w_op_in;
            r_data  <= bus.cmd_data;
            r_steps <= w_steps_in;
            r_state <= S_EXEC;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_EXEC: begin
          r_steps <= r_steps - CNTW'(1);
          if (r_steps <= CNTW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Ripple-carry/borrow toggle enables built as a running AND so no vector
  // bit depends on another bit of the same signal.
  always_comb begin
    logic v_up;
    logic v_dn;
    v_up  = 1'b1;
    v_dn  = 1'b1;
    w_tup = '0;
    w_tdn = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_tup[i] = v_up;
      w_tdn[i] = v_dn;
      v_up     = v_up & r_q[i];
      v_dn     = v_dn & ~r_q[i];
    end
  end

  assign w_shift = {r_q[WIDTH-2:0], r_data[0]};

  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == S_EXEC) begin
      case (r_op)
        OP_HOLD:   begin w_j = '0;      w_k = '0;       end
        OP_CLEAR:  begin w_j = '0;      w_k = r_data;   end
        OP_SET:    begin w_j = r_data;  w_k = '0;       end
        OP_TOGGLE: begin w_j = r_data;  w_k = r_data;   end
        OP_LOAD:   begin w_j = r_data;  w_k = ~r_data;  end
        OP_CNT_UP: begin w_j = w_tup;   w_k = w_tup;    end
        OP_CNT_DN: begin w_j = w_tdn;   w_k = w_tdn;    end
        OP_SHIFT:  begin w_j = w_shift; w_k = ~w_shift; end
        default:   begin w_j = '0;      w_k = '0;       end
      endcase
    end
  end

  assign w_wrap = (r_state == S_EXEC) &&
                  (((r_op == OP_CNT_UP) && (&r_q)) ||
                   ((r_op == OP_CNT_DN) && (r_q == '0)));

  assign w_q_next = (w_j & ~r_q) | (~w_k & r_q);

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wrap      = w_wrap;
  assign bus.j_o       = w_j;
  assign bus.k_o       = w_k;
  assign bus.q_o       = r_q;

endmodule
